// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand entry stage: key codes,
// opcodes, FSM encoding and the entry magnitude limit.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_MUL = 4'd11;
    localparam logic [3:0] KEY_SUB = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_NEG = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam logic [14:0] MAG_MAX  = 15'd32767;
    // Downstream arithmetic latches the opcode over two cycles
    localparam logic [1:0]  WAIT_CYC = 2'd2;

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        op = OP_ADD;
        if (k == KEY_MUL) op = OP_MUL;
        if (k == KEY_SUB) op = OP_SUB;
        return op;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: mag*10 + digit with overflow detection.
// ENTRY_SATURATE_EN selects clamp-to-max instead of discarding the digit.
module dec_accum
    import calc_pkg::*;
(
    input  logic [14:0] mag_i,
    input  logic [3:0]  digit_i,
    output logic [14:0] mag_o,
    output logic        ovf_o
);

    // 19 bits holds the worst case 32767*10+9
    logic [18:0] prod;

    always_comb begin
        prod  = 19'(mag_i) * 19'd10 + 19'(digit_i);
        ovf_o = prod > 19'(MAG_MAX);
        if (ovf_o) begin
`ifdef ENTRY_SATURATE_EN
            mag_o = MAG_MAX;
`else
            mag_o = mag_i;
`endif
        end else begin
            mag_o = prod[14:0];
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry stage feeding the arithmetic module.
// Overflow behaviour of digit entry is selected by ENTRY_SATURATE_EN.
module operand_entry
    import calc_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic signed [15:0] answer,
    output logic signed [15:0] V1,
    output logic signed [15:0] V2,
    output logic [1:0]         opcode,
    output logic               newop,
    output logic signed [15:0] display,
    output logic               ovf,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [14:0]        mag_q, mag_d;
    logic               neg_q, neg_d;
    logic               has_q, has_d;
    logic signed [15:0] v2_q, v2_d;
    logic [1:0]         op_q, op_d;
    logic               newop_q, newop_d;
    logic               ovf_q, ovf_d;
    logic signed [15:0] res_q, res_d;
    logic [1:0]         cnt_q, cnt_d;

    logic [14:0]        acc_mag;
    logic               acc_ovf;
    logic [15:0]        mag_ext;
    logic signed [15:0] v1_w;

    dec_accum u_acc (
        .mag_i   (mag_q),
        .digit_i (key_code),
        .mag_o   (acc_mag),
        .ovf_o   (acc_ovf)
    );

    assign mag_ext = {1'b0, mag_q};
    assign v1_w    = neg_q ? $signed(~mag_ext + 16'd1) : $signed(mag_ext);

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        has_d   = has_q;
        v2_d    = v2_q;
        op_d    = op_q;
        newop_d = 1'b0;
        ovf_d   = ovf_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WAIT) begin
            if (cnt_q == 2'd0) begin
                res_d   = answer;
                state_d = ST_RESULT;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (key_valid) begin
            if (key_code == KEY_CLR) begin
                state_d = ST_FIRST;
                mag_d   = '0;
                neg_d   = 1'b0;
                has_d   = 1'b0;
                v2_d    = '0;
                op_d    = OP_ADD;
                ovf_d   = 1'b0;
                res_d   = '0;
            end else if (is_digit(key_code)) begin
                if (state_q == ST_RESULT) begin
                    mag_d   = {11'd0, key_code};
                    neg_d   = 1'b0;
                    has_d   = 1'b1;
                    state_d = ST_FIRST;
                end else if (acc_ovf) begin
                    mag_d = acc_mag;
                    ovf_d = 1'b1;
                end else begin
                    mag_d = acc_mag;
                    has_d = 1'b1;
                end
            end else if (key_code == KEY_NEG) begin
                if (state_q != ST_RESULT) neg_d = ~neg_q;
            end else if (key_code == KEY_EQ) begin
                if (state_q == ST_SECOND) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_CYC;
                end
            end else if (state_q != ST_SECOND || !has_q) begin
                // Operator: in SECOND before any digit it only swaps the opcode
                op_d    = key_to_op(key_code);
                newop_d = 1'b1;
                if (state_q != ST_SECOND) begin
                    v2_d    = (state_q == ST_RESULT) ? res_q : v1_w;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    has_d   = 1'b0;
                    state_d = ST_SECOND;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FIRST;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            has_q   <= 1'b0;
            v2_q    <= '0;
            op_q    <= OP_ADD;
            newop_q <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            has_q   <= has_d;
            v2_q    <= v2_d;
            op_q    <= op_d;
            newop_q <= newop_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign V1      = v1_w;
    assign V2      = v2_q;
    assign opcode  = op_q;
    assign newop   = newop_q;
    assign ovf     = ovf_q;
    assign display = (state_q == ST_RESULT) ? res_q : v1_w;
    // Final WAIT cycle (count 0) is the capture cycle, so busy drops there
    assign busy    = (state_q == ST_WAIT) && (cnt_q != 2'd0);

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios plus random keys
// checked every cycle against an integer-level behavioural model.
module tb_operand_entry;

    logic               clock;
    logic               reset;
    logic               key_valid;
    logic [3:0]         key_code;
    logic signed [15:0] answer;
    logic signed [15:0] V1, V2, display;
    logic [1:0]         opcode;
    logic               newop, ovf, busy;

    operand_entry dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .answer    (answer),
        .V1        (V1),
        .V2        (V2),
        .opcode    (opcode),
        .newop     (newop),
        .display   (display),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [15:0] ans_val = 16'sd0;

    localparam int M_FIRST = 0, M_SECOND = 1, M_WAIT = 2, M_RES = 3;
    int m_mode, m_mag, m_neg, m_has, m_v2, m_op, m_res, m_ovf, m_newop, m_since;

    task automatic chk(input string tag, input int got, input int exp_v);
        n_tests++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    function automatic int m_v1();
        return (m_neg != 0) ? -m_mag : m_mag;
    endfunction

    task automatic model_reset();
        m_mode = M_FIRST; m_mag = 0; m_neg = 0; m_has = 0; m_v2 = 0;
        m_op = 0; m_res = 0; m_ovf = 0; m_newop = 0; m_since = 0;
    endtask

    task automatic model_clear_entry();
        m_mag = 0; m_neg = 0; m_has = 0;
    endtask

    // One rising edge of the specified behaviour, from the key seen at that edge
    task automatic model_update(input int v, input int c, input int a);
        int nv;
        m_newop = 0;
        if (m_mode == M_WAIT) begin
            m_since++;
            if (m_since == 3) begin
                m_res  = a;
                m_mode = M_RES;
            end
        end else if (v != 0) begin
            if (c == 14) begin
                model_reset();
            end else if (c <= 9) begin
                if (m_mode == M_RES) begin
                    m_mag = c; m_neg = 0; m_has = 1; m_mode = M_FIRST;
                end else begin
                    nv = m_mag * 10 + c;
                    if (nv <= 32767) begin
                        m_mag = nv; m_has = 1;
                    end else begin
                        m_ovf = 1;
`ifdef ENTRY_SATURATE_EN
                        m_mag = 32767;
`endif
                    end
                end
            end else if (c == 15) begin
                if (m_mode != M_RES) m_neg = 1 - m_neg;
            end else if (c == 13) begin
                if (m_mode == M_SECOND) begin
                    m_mode = M_WAIT; m_since = 0;
                end
            end else begin
                if (m_mode == M_FIRST || m_mode == M_RES) begin
                    m_v2 = (m_mode == M_RES) ? m_res : m_v1();
                    model_clear_entry();
                    m_op = c - 10; m_newop = 1; m_mode = M_SECOND;
                end else if (m_has == 0) begin
                    m_op = c - 10; m_newop = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("V1", int'(V1), m_v1());
        chk("V2", int'(V2), m_v2);
        chk("opcode", int'(opcode), m_op);
        chk("newop", int'(newop), m_newop);
        chk("display", int'(display), (m_mode == M_RES) ? m_res : m_v1());
        chk("ovf", int'(ovf), m_ovf);
        chk("busy", int'(busy), (m_mode == M_WAIT && m_since < 2) ? 1 : 0);
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clock);
        key_valid = v;
        key_code  = c;
        answer    = ans_val;
        @(posedge clock);
        model_update(int'(v), int'(c), int'(answer));
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] c);
        step(1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, away from any edge
    task automatic do_reset();
        @(negedge clock);
        #2;
        key_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_V1", int'(V1), 0);
        chk("rst_V2", int'(V2), 0);
        chk("rst_busy", int'(busy), 0);
        check_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    int cnt;

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; answer = 16'sd0;
        model_reset();
        do_reset();

        // Basic add: 123 + 45
        ans_val = 16'sd168;
        press(4'd1); press(4'd2); press(4'd3); press(4'd10);
        chk("t1_v2", int'(V2), 123);
        chk("t1_newop", int'(newop), 1);
        chk("t1_op", int'(opcode), 0);
        press(4'd4);
        chk("t1_newop_once", int'(newop), 0);
        press(4'd5);
        chk("t1_v1", int'(V1), 45);
        press(4'd13);
        cnt = int'(busy);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            cnt += int'(busy);
        end
        chk("t1_busy_cycles", cnt, 2);
        chk("t1_display", int'(display), 168);

        // Entry overflow
        press(4'd14);
        press(4'd3); press(4'd2); press(4'd7); press(4'd6); press(4'd8); press(4'd9);
        chk("t2_ovf", int'(ovf), 1);
`ifdef ENTRY_SATURATE_EN
        chk("t2_v1", int'(V1), 32767);
`else
        chk("t2_v1", int'(V1), 3276);
`endif

        // Negative first operand
        press(4'd14);
        press(4'd5); press(4'd15); press(4'd11); press(4'd7);
        chk("t3_v2", int'(V2), -5);
        chk("t3_op", int'(opcode), 1);
        chk("t3_v1", int'(V1), 7);

        // Operator replacement before any second digit
        press(4'd14);
        cnt = 0;
        press(4'd9);
        press(4'd10); cnt += int'(newop);
        press(4'd12); cnt += int'(newop);
        chk("t4_pulses", cnt, 2);
        press(4'd2);
        press(4'd11);
        chk("t4_op_kept", int'(opcode), 2);
        chk("t4_no_pulse", int'(newop), 0);

        // Chaining from RESULT, then clear
        press(4'd14);
        ans_val = 16'sd30;
        press(4'd6); press(4'd11); press(4'd5); press(4'd13);
        idle(4);
        press(4'd11);
        chk("t5_v2", int'(V2), 30);
        chk("t5_v1", int'(V1), 0);
        chk("t5_newop", int'(newop), 1);
        press(4'd14);
        chk("t5_clr_v2", int'(V2), 0);
        chk("t5_clr_disp", int'(display), 0);

        // Reset during WAIT
        press(4'd1); press(4'd10); press(4'd2); press(4'd13);
        idle(1);
        do_reset();
        idle(3);
        press(4'd13);
        chk("t6_first_eq_ignored", int'(busy), 0);

        // Random keys with occasional mid-cycle reset
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [3:0] c;
            ans_val = 16'($urandom);
            r = $urandom_range(0, 99);
            if (r < 80)      c = 4'((r - 40) % 10);
            else if (r < 86) c = 4'(10 + (r - 80) % 3);
            else if (r < 92) c = 4'd13;
            else if (r < 94) c = 4'd14;
            else             c = 4'd15;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(r >= 40, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
